operand_bypass: RTL

Parametrised operand-fetch and forwarding stage between ID and EX. It registers NUM_SRC register-file read ports into ID_EX and resolves RAW hazards by comparing source addresses against the destination addresses of NUM_STG downstream stages. Forwarding selects are generated internally; the ID stage no longer supplies byp* flags. The block also flags load-use hazards when a matching stage has no result yet, and pipelines source 0 into EX_DM as store data.

---
 rtl/operand_bypass.sv | 99 +++++++++
 1 files changed

// File: rtl/operand_bypass.sv
// Operand fetch and forwarding between ID and EX: ID_EX operand flops, youngest-wins bypass, load-use detect, store-data flop.
// Latency: 1 cycle from src_addr/rf_data into ID_EX; opnd/byp_hit/load_use_stall are combinational from ID_EX and stg_*.
// Backpressure: stall_ID_EX holds ID_EX (flush wins), stall_EX_DM holds store data; load_use_stall asks the control to hold and bubble.
module operand_bypass #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int NUM_SRC  = 2,
  parameter int NUM_STG  = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stall_ID_EX,
  input  logic                       flush_ID_EX,
  input  logic                       stall_EX_DM,
  input  logic [NUM_SRC*ADDR_W-1:0]  src_addr,
  input  logic [NUM_SRC-1:0]         src_en,
  input  logic [NUM_SRC*DATA_W-1:0]  rf_data,
  input  logic [NUM_STG*ADDR_W-1:0]  stg_dst,
  input  logic [NUM_STG-1:0]         stg_we,
  input  logic [NUM_STG-1:0]         stg_rdy,
  input  logic [NUM_STG*DATA_W-1:0]  stg_data,
  output logic [NUM_SRC*DATA_W-1:0]  opnd,
  output logic [NUM_SRC-1:0]         byp_hit,
  output logic                       load_use_stall,
  output logic [DATA_W-1:0]          st_data_EX_DM
);

  logic                      vld_q;
  logic [NUM_SRC*ADDR_W-1:0] addr_q;
  logic [NUM_SRC-1:0]        en_q;
  logic [NUM_SRC*DATA_W-1:0] rf_q;
  logic [NUM_SRC-1:0]        src_stall;

  // ID_EX register: flush clears valid/enables but leaves the payload, stall holds everything
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= 1'b0;
      addr_q <= '0;
      en_q   <= '0;
      rf_q   <= '0;
    end else if (flush_ID_EX) begin
      vld_q  <= 1'b0;
      en_q   <= '0;
    end else if (!stall_ID_EX) begin
      vld_q  <= 1'b1;
      addr_q <= src_addr;
      en_q   <= src_en;
      rf_q   <= rf_data;
    end
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] rf;
    logic              en;
    logic              is_zero;
    logic              hit;
    logic              rdy;
    logic [DATA_W-1:0] fwd;

    assign addr    = addr_q[i*ADDR_W +: ADDR_W];
    assign rf      = rf_q[i*DATA_W +: DATA_W];
    assign en      = en_q[i];
    assign is_zero = (ZERO_REG != 0) && (addr == '0);

    // Scan oldest to youngest so the youngest matching stage overwrites any older one
    always_comb begin
      hit = 1'b0;
      rdy = 1'b1;
      fwd = '0;
      for (int s = NUM_STG - 1; s >= 0; s--) begin
        if (vld_q && en && stg_we[s] && !is_zero &&
            (stg_dst[s*ADDR_W +: ADDR_W] == addr)) begin
          hit = 1'b1;
          rdy = stg_rdy[s];
          fwd = stg_data[s*DATA_W +: DATA_W];
        end
      end
    end

    // Register 0 never matches, so the hardwired zero only replaces the RF value
    assign opnd[i*DATA_W +: DATA_W] = hit ? fwd : (is_zero ? '0 : rf);
    assign byp_hit[i]               = hit;
    assign src_stall[i]             = hit & ~rdy;
  end

  assign load_use_stall = |src_stall;

  // Store data follows source 0 into EX_DM; a load-use bubble carries zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_data_EX_DM <= '0;
    end else if (!stall_EX_DM) begin
      st_data_EX_DM <= load_use_stall ? '0 : opnd[DATA_W-1:0];
    end
  end

endmodule
